j_jslave: RTL and testbench

Bus target (responder) for Jerry's 16-bit external data bus. It answers read and write cycles from an external master (68000, GPU, blitter) that hit Jerry's address window, and turns them into internal register or DSP-RAM accesses. DSP local RAM is 32 bits wide, so 16-bit external accesses to it are paired through word latches, honouring the `bigend` word order from Jerry's configuration. This block is the responder counterpart to Jerry's bus-master data/address path.

---
 rtl/j_jslave.sv | 148 ++++++++++++++
 tb/tb_j_jslave.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/j_jslave.sv
// j_jslave: external 16-bit bus responder for Jerry. It turns master cycles into
// internal register/DSP-RAM accesses and pairs 16-bit halves of 32-bit RAM words through latches.
module j_jslave #(
    parameter logic [7:0]  BASE_HI = 8'hF1,
    parameter logic [23:0] RAM_LO  = 24'hF1B000,
    parameter logic [23:0] RAM_HI  = 24'hF1CFFF,
    parameter int unsigned TMO     = 15
) (
    input  logic        sys_clk,
    input  logic        resetl,
    input  logic [23:0] ain,
    input  logic [15:0] din,
    input  logic        rw,
    input  logic        strobe,
    input  logic        bigend,
    output logic [23:0] ra,
    output logic [31:0] wd,
    output logic        re,
    output logic        we,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic [15:0] dout,
    output logic        doe,
    output logic        ack,
    output logic        tmo_err
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ACK, S_HOLD} state_t;

    localparam logic [3:0] TMO_LAST = 4'(TMO - 1);

    state_t      state_q, state_d;
    logic [23:0] ra_q, ra_d;
    logic [31:0] wd_q, wd_d;
    logic [15:0] dout_q, dout_d;
    logic [15:0] hi_lat_q, hi_lat_d;
    logic [15:0] lo_lat_q, lo_lat_d;
    logic        rd_q, rd_d;
    logic        ram_q, ram_d;
    logic        tmo_q, tmo_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        sel;
    logic        ram_hit;
    logic        hi_word;
    logic        latch_only;

    assign sel        = strobe && (ain[23:16] == BASE_HI);
    assign ram_hit    = (ain >= RAM_LO) && (ain <= RAM_HI);
    assign hi_word    = ain[1] ^ bigend;
    // High-word writes and low-word reads are served purely from the latches.
    assign latch_only = ram_hit && (rw ? !hi_word : hi_word);

    always_comb begin
        state_d  = state_q;
        ra_d     = ra_q;
        wd_d     = wd_q;
        dout_d   = dout_q;
        hi_lat_d = hi_lat_q;
        lo_lat_d = lo_lat_q;
        rd_d     = rd_q;
        ram_d    = ram_q;
        tmo_d    = tmo_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (sel) begin
                    rd_d  = rw;
                    ram_d = ram_hit;
                    tmo_d = 1'b0;
                    if (latch_only) begin
                        if (rw) dout_d   = lo_lat_q;
                        else    hi_lat_d = din;
                        state_d = S_ACK;
                    end else begin
                        ra_d    = ram_hit ? {ain[23:2], 2'b00} : ain;
                        wd_d    = ram_hit ? {hi_lat_q, din} : {din, din};
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rvalid) begin
                    if (rd_q) begin
                        if (ram_q) begin
                            dout_d   = rdata[31:16];
                            lo_lat_d = rdata[15:0];
                        end else begin
                            dout_d = rdata[15:0];
                        end
                    end
                    state_d = S_ACK;
                end else if (cnt_q == TMO_LAST) begin
                    dout_d  = '1;
                    tmo_d   = 1'b1;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ACK: state_d = S_HOLD;
            S_HOLD: begin
                if (!strobe) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state_q  <= S_IDLE;
            ra_q     <= '0;
            wd_q     <= '0;
            dout_q   <= '0;
            hi_lat_q <= '0;
            lo_lat_q <= '0;
            rd_q     <= 1'b0;
            ram_q    <= 1'b0;
            tmo_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            wd_q     <= wd_d;
            dout_q   <= dout_d;
            hi_lat_q <= hi_lat_d;
            lo_lat_q <= lo_lat_d;
            rd_q     <= rd_d;
            ram_q    <= ram_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ra      = ra_q;
    assign wd      = wd_q;
    assign dout    = dout_q;
    assign re      = (state_q == S_REQ) && rd_q;
    assign we      = (state_q == S_REQ) && !rd_q;
    assign doe     = ((state_q == S_ACK) || (state_q == S_HOLD)) && rd_q;
    assign ack     = (state_q == S_ACK);
    assign tmo_err = (state_q == S_ACK) && tmo_q;

endmodule

// File: tb/tb_j_jslave.sv
// Scoreboard bench for j_jslave: the stimulus pushes expected internal accesses and bus
// responses computed from the latch-pairing rules; independent monitors pop and compare.
module tb_j_jslave;

    logic        sys_clk = 1'b0;
    logic        resetl  = 1'b0;
    logic [23:0] ain     = '0;
    logic [15:0] din     = '0;
    logic        rw      = 1'b0;
    logic        strobe  = 1'b0;
    logic        bigend  = 1'b0;
    logic [31:0] rdata   = '0;
    logic        rvalid  = 1'b0;
    logic [23:0] ra;
    logic [31:0] wd;
    logic        re, we, doe, ack, tmo_err;
    logic [15:0] dout;

    j_jslave #(
        .BASE_HI(8'hF1),
        .RAM_LO (24'hF1B000),
        .RAM_HI (24'hF1CFFF),
        .TMO    (15)
    ) dut (
        .sys_clk(sys_clk), .resetl(resetl), .ain(ain), .din(din), .rw(rw),
        .strobe(strobe), .bigend(bigend), .ra(ra), .wd(wd), .re(re), .we(we),
        .rdata(rdata), .rvalid(rvalid), .dout(dout), .doe(doe), .ack(ack),
        .tmo_err(tmo_err)
    );

    always #5 sys_clk = ~sys_clk;

    int unsigned cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          rd;
        logic [23:0] ra;
        logic [31:0] wd;
    } acc_t;

    typedef struct {
        bit          rd;
        logic [15:0] dout;
        bit          tmo;
        int unsigned cyc;
    } rsp_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];
    acc_t mon_a;
    rsp_t mon_r;

    // Reference state: the two pairing latches as the bus master would see them.
    logic [15:0] hi_m = '0;
    logic [15:0] lo_m = '0;

    int unsigned resp_delay = 0;
    logic [31:0] resp_data  = '0;
    int unsigned rsp_d;
    logic [31:0] rsp_v;
    bit          resp_busy  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Internal-side responder: rvalid arrives resp_delay cycles after re/we (0 = never).
    initial forever begin
        @(negedge sys_clk);
        if (resetl && (re || we)) begin
            resp_busy = 1'b1;
            rsp_d     = resp_delay;
            rsp_v     = resp_data;
            if (rsp_d != 0) begin
                repeat (rsp_d) @(negedge sys_clk);
                rvalid = 1'b1;
                rdata  = rsp_v;
                @(negedge sys_clk);
                rvalid = 1'b0;
                rdata  = '0;
            end
            resp_busy = 1'b0;
        end
    end

    // Monitor: compares every internal request and every bus acknowledge.
    initial forever begin
        @(negedge sys_clk);
        if (resetl) begin
            if (re || we) begin
                if (acc_q.size() == 0) begin
                    chk("unexpected_access", {30'b0, re, we}, 32'd0);
                end else begin
                    mon_a = acc_q.pop_front();
                    chk("acc_kind", {30'b0, re, we}, {30'b0, mon_a.rd, !mon_a.rd});
                    chk("acc_ra", {8'b0, ra}, {8'b0, mon_a.ra});
                    if (!mon_a.rd) chk("acc_wd", wd, mon_a.wd);
                end
            end
            if (ack) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_ack", {31'b0, ack}, 32'd0);
                end else begin
                    mon_r = rsp_q.pop_front();
                    chk("ack_tmo_err", {31'b0, tmo_err}, {31'b0, mon_r.tmo});
                    chk("ack_doe", {31'b0, doe}, {31'b0, mon_r.rd});
                    if (mon_r.rd) chk("ack_dout", {16'b0, dout}, {16'b0, mon_r.dout});
                    chk("ack_cycle", cyc, mon_r.cyc);
                end
            end else if (tmo_err) begin
                chk("tmo_without_ack", {31'b0, tmo_err}, 32'd0);
            end
        end
    end

    task automatic do_cycle(input logic [23:0] a, input bit r, input logic [15:0] d_in,
                            input bit be, input int unsigned dly, input logic [31:0] rd_data,
                            input bit early);
        bit   sel, ram, hi, lonly, tmo, got;
        int unsigned lat;
        acc_t ac;
        rsp_t rs;
        sel   = (a[23:16] == 8'hF1);
        ram   = (a >= 24'hF1B000) && (a <= 24'hF1CFFF);
        hi    = a[1] ^ be;
        lonly = ram && (r ? !hi : hi);
        tmo   = !lonly && (dly == 0 || dly > 15);
        @(negedge sys_clk);
        if (sel) begin
            rs.rd   = r;
            rs.tmo  = tmo;
            rs.dout = '0;
            if (lonly) begin
                lat = 1;
                if (r) rs.dout = lo_m;
                else   hi_m    = d_in;
            end else begin
                ac.rd = r;
                ac.ra = ram ? {a[23:2], 2'b00} : a;
                ac.wd = ram ? {hi_m, d_in} : {d_in, d_in};
                acc_q.push_back(ac);
                lat = tmo ? 17 : 2 + dly;
                if (tmo) rs.dout = 16'hFFFF;
                else if (ram) begin
                    rs.dout = rd_data[31:16];
                    if (r) lo_m = rd_data[15:0];
                end else rs.dout = rd_data[15:0];
            end
            rs.cyc = cyc + lat;
            rsp_q.push_back(rs);
        end
        resp_delay = dly;
        resp_data  = rd_data;
        ain    = a;
        rw     = r;
        din    = d_in;
        bigend = be;
        strobe = 1'b1;
        got    = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge sys_clk);
            if (early && n == 1) strobe = 1'b0;
            if (ack) got = 1'b1;
        end
        if (sel) chk("ack_seen", {31'b0, got}, 32'd1);
        else     chk("unsel_no_ack", {31'b0, got}, 32'd0);
        strobe = 1'b0;
        for (int n = 0; n < 40 && resp_busy; n++) @(negedge sys_clk);
        repeat (2) @(negedge sys_clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          r, be, early;
        int unsigned sel3, dly, acks;
        logic [23:0] a;

        repeat (3) @(negedge sys_clk);
        chk("rst_ra", {8'b0, ra}, 32'd0);
        chk("rst_wd", wd, 32'd0);
        chk("rst_dout", {16'b0, dout}, 32'd0);
        chk("rst_ctl", {27'b0, re, we, doe, ack, tmo_err}, 32'd0);
        resetl = 1'b1;
        repeat (2) @(negedge sys_clk);

        do_cycle(24'hF1B000, 1'b1, 16'h0,    1'b0, 1, 32'h0, 1'b0);
        do_cycle(24'hF10020, 1'b1, 16'h0,    1'b0, 2, 32'h1234ABCD, 1'b0);
        do_cycle(24'hF1B000, 1'b0, 16'h1111, 1'b1, 1, 32'h0, 1'b0);
        do_cycle(24'hF1B002, 1'b0, 16'h2222, 1'b1, 1, 32'h0, 1'b0);
        do_cycle(24'hF1B006, 1'b1, 16'h0,    1'b0, 1, 32'hDEADBEEF, 1'b0);
        do_cycle(24'hF1B004, 1'b1, 16'h0,    1'b0, 1, 32'h0, 1'b0);
        do_cycle(24'hF10040, 1'b1, 16'h0,    1'b0, 0, 32'h0, 1'b0);
        do_cycle(24'hF1B004, 1'b1, 16'h0,    1'b0, 1, 32'h0, 1'b0);
        do_cycle(24'hF1CFFE, 1'b1, 16'h0,    1'b0, 3, 32'hCAFEF00D, 1'b0);
        do_cycle(24'hF1CFFC, 1'b1, 16'h0,    1'b0, 3, 32'h0, 1'b0);
        do_cycle(24'hF1D000, 1'b1, 16'h0,    1'b0, 3, 32'h55AA6699, 1'b0);
        do_cycle(24'hF1AFFE, 1'b0, 16'h7777, 1'b0, 15, 32'h0, 1'b0);
        do_cycle(24'hE00000, 1'b1, 16'h0,    1'b0, 1, 32'h0, 1'b0);
        do_cycle(24'hF10100, 1'b1, 16'h0,    1'b0, 5, 32'h00004321, 1'b1);

        // Reset in the middle of WAIT: the cycle is abandoned and a late rvalid is ignored.
        acc_q.push_back('{rd: 1'b1, ra: 24'hF10080, wd: 32'h0});
        @(negedge sys_clk);
        resp_delay = 12;
        resp_data  = 32'h0BAD0BAD;
        ain = 24'hF10080; rw = 1'b1; strobe = 1'b1;
        repeat (4) @(negedge sys_clk);
        @(posedge sys_clk);
        #2 resetl = 1'b0;
        #1;
        chk("midrst_ra", {8'b0, ra}, 32'd0);
        chk("midrst_wd", wd, 32'd0);
        chk("midrst_dout", {16'b0, dout}, 32'd0);
        chk("midrst_ctl", {27'b0, re, we, doe, ack, tmo_err}, 32'd0);
        acc_q.delete();
        rsp_q.delete();
        hi_m = '0;
        lo_m = '0;
        strobe = 1'b0;
        repeat (2) @(negedge sys_clk);
        resetl = 1'b1;
        acks = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (ack) acks++;
        end
        chk("no_ack_after_reset", acks, 32'd0);
        do_cycle(24'hF1B002, 1'b1, 16'h0, 1'b1, 1, 32'h0, 1'b0);

        for (int i = 0; i < 120; i++) begin
            sel3 = $urandom_range(0, 9);
            if (sel3 == 0)      a = {($urandom_range(0, 1) != 0) ? 8'hF0 : 8'hF2, 16'($urandom)};
            else if (sel3 < 5)  a = {8'hF1, 16'($urandom_range(0, 16'hAFFF))};
            else                a = 24'hF1B000 + 24'($urandom_range(0, 24'h1FFF));
            r     = ($urandom_range(0, 1) != 0);
            be    = ($urandom_range(0, 1) != 0);
            dly   = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 19) : $urandom_range(1, 6);
            early = ($urandom_range(0, 7) == 0);
            do_cycle(a, r, 16'($urandom), be, dly, $urandom, early);
        end

        repeat (5) @(negedge sys_clk);
        chk("acc_queue_drained", 32'(acc_q.size()), 32'd0);
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
